// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a framed message stream into one output stream; messages are held until complete.
// Optional macro SAMPLE_MSG_COMBINER_DROP_COUNT_EN adds a saturating dropped-word counter output.
module sample_msg_combiner #(
    parameter int unsigned WIDTH               = 32,
    parameter int unsigned LENGTH_WIDTH        = 10,
    parameter int unsigned SAMPLE_BUFFER_DEPTH = 64,
    parameter int unsigned MSG_BUFFER_DEPTH    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_samples,
    input  logic             in_samples_nd,
    input  logic [WIDTH-1:0] in_msg,
    input  logic             in_msg_nd,
    output logic [WIDTH-1:0] out_data,
    output logic             out_nd,
    output logic             error
`ifdef SAMPLE_MSG_COMBINER_DROP_COUNT_EN
    ,
    output logic [15:0]      out_drop_count
`endif
);

    localparam int unsigned SAW = $clog2(SAMPLE_BUFFER_DEPTH);
    localparam int unsigned MAW = $clog2(MSG_BUFFER_DEPTH);
    localparam logic [SAW:0] S_DEPTH = (SAW+1)'(SAMPLE_BUFFER_DEPTH);
    localparam logic [MAW:0] M_DEPTH = (MAW+1)'(MSG_BUFFER_DEPTH);

    typedef enum logic {ST_IDLE, ST_MSG} state_t;

    // Sample FIFO
    logic [WIDTH-1:0] r_s_mem [SAMPLE_BUFFER_DEPTH];
    logic [SAW:0]     r_s_wp, r_s_rp;
    logic [SAW:0]     w_s_cnt;
    logic             w_s_empty, w_s_full, w_s_wr, w_s_rd, w_s_dropped;
    logic [WIDTH-1:0] w_s_head;

    // Message FIFO
    logic [WIDTH-1:0] r_m_mem [MSG_BUFFER_DEPTH];
    logic [MAW:0]     r_m_wp, r_m_rp;
    logic [MAW:0]     w_m_cnt, w_m_free;
    logic             w_m_empty, w_m_wr, w_m_rd;
    logic [WIDTH-1:0] w_m_head;
    logic             w_m_head_cont;

    // Receive tracking
    logic [LENGTH_WIDTH-1:0] r_rx_rem, w_rx_rem_nxt;
    logic                    r_rx_drop, w_rx_drop_nxt;
    logic [LENGTH_WIDTH-1:0] w_len;
    logic                    w_hdr_fits;
    logic [1:0]              w_cmp_inc;
    logic                    w_cmp_dec;
    logic                    w_m_err, w_m_dropped;
    logic [MAW:0]            r_cmp_cnt;

    // Emit FSM
    state_t                  r_state, w_state_nxt;
    logic [LENGTH_WIDTH-1:0] r_emit_rem, w_emit_rem_nxt;
    logic [WIDTH-1:0]        r_out_data, w_out_data_nxt;
    logic                    r_out_nd, w_out_nd_nxt;
    logic                    r_error;

    assign w_s_cnt   = r_s_wp - r_s_rp;
    assign w_s_empty = (w_s_cnt == '0);
    assign w_s_full  = (w_s_cnt == S_DEPTH);
    assign w_s_head  = r_s_mem[r_s_rp[SAW-1:0]];
    // A read in the same cycle frees the slot, so a full FIFO can still accept
    assign w_s_wr      = in_samples_nd && !in_samples[WIDTH-1] && (!w_s_full || w_s_rd);
    assign w_s_dropped = in_samples_nd && !w_s_wr;

    assign w_m_cnt       = r_m_wp - r_m_rp;
    assign w_m_free      = M_DEPTH - w_m_cnt;
    assign w_m_empty     = (w_m_cnt == '0);
    assign w_m_head      = r_m_mem[r_m_rp[MAW-1:0]];
    assign w_m_head_cont = !w_m_empty && !w_m_head[WIDTH-1];

    assign w_len      = in_msg[WIDTH-2 -: LENGTH_WIDTH];
    assign w_hdr_fits = (32'(w_len) + 32'd1) <= 32'(w_m_free);

    // Message receive: accept whole messages that fit, track and drop the rest
    always_comb begin
        w_rx_rem_nxt  = r_rx_rem;
        w_rx_drop_nxt = r_rx_drop;
        w_m_wr        = 1'b0;
        w_cmp_inc     = 2'd0;
        w_m_err       = 1'b0;
        w_m_dropped   = 1'b0;
        if (in_msg_nd) begin
            if (in_msg[WIDTH-1]) begin
                if (r_rx_rem != '0) begin
                    w_m_err = 1'b1;
                    if (!r_rx_drop) w_cmp_inc = 2'd1;
                end
                w_rx_rem_nxt = w_len;
                if (w_hdr_fits) begin
                    w_m_wr        = 1'b1;
                    w_rx_drop_nxt = 1'b0;
                    if (w_len == '0) w_cmp_inc = w_cmp_inc + 2'd1;
                end else begin
                    w_m_err       = 1'b1;
                    w_m_dropped   = 1'b1;
                    w_rx_drop_nxt = 1'b1;
                end
            end else if (r_rx_rem == '0) begin
                w_m_err     = 1'b1;
                w_m_dropped = 1'b1;
            end else begin
                w_rx_rem_nxt = r_rx_rem - LENGTH_WIDTH'(1);
                if (r_rx_drop) begin
                    w_m_dropped = 1'b1;
                end else begin
                    w_m_wr = 1'b1;
                    if (r_rx_rem == LENGTH_WIDTH'(1)) w_cmp_inc = 2'd1;
                end
            end
        end
    end

    // Emit: finish the current message (stopping early if truncated), else message header, else sample
    always_comb begin
        w_state_nxt    = r_state;
        w_emit_rem_nxt = r_emit_rem;
        w_out_data_nxt = r_out_data;
        w_out_nd_nxt   = 1'b0;
        w_s_rd         = 1'b0;
        w_m_rd         = 1'b0;
        w_cmp_dec      = 1'b0;
        if (r_state == ST_MSG && w_m_head_cont) begin
            w_m_rd         = 1'b1;
            w_out_nd_nxt   = 1'b1;
            w_out_data_nxt = w_m_head;
            w_emit_rem_nxt = r_emit_rem - LENGTH_WIDTH'(1);
            if (r_emit_rem == LENGTH_WIDTH'(1)) w_state_nxt = ST_IDLE;
        end else begin
            w_state_nxt = ST_IDLE;
            if (r_cmp_cnt != '0) begin
                w_m_rd         = 1'b1;
                w_cmp_dec      = 1'b1;
                w_out_nd_nxt   = 1'b1;
                w_out_data_nxt = w_m_head;
                w_emit_rem_nxt = w_m_head[WIDTH-2 -: LENGTH_WIDTH];
                if (w_m_head[WIDTH-2 -: LENGTH_WIDTH] != '0) w_state_nxt = ST_MSG;
            end else if (!w_s_empty) begin
                w_s_rd         = 1'b1;
                w_out_nd_nxt   = 1'b1;
                w_out_data_nxt = w_s_head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s_wr) r_s_mem[r_s_wp[SAW-1:0]] <= in_samples;
        if (w_m_wr) r_m_mem[r_m_wp[MAW-1:0]] <= in_msg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_wp     <= '0;
            r_s_rp     <= '0;
            r_m_wp     <= '0;
            r_m_rp     <= '0;
            r_rx_rem   <= '0;
            r_rx_drop  <= 1'b0;
            r_cmp_cnt  <= '0;
            r_state    <= ST_IDLE;
            r_emit_rem <= '0;
            r_out_data <= '0;
            r_out_nd   <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            if (w_s_wr) r_s_wp <= r_s_wp + (SAW+1)'(1);
            if (w_s_rd) r_s_rp <= r_s_rp + (SAW+1)'(1);
            if (w_m_wr) r_m_wp <= r_m_wp + (MAW+1)'(1);
            if (w_m_rd) r_m_rp <= r_m_rp + (MAW+1)'(1);
            r_rx_rem   <= w_rx_rem_nxt;
            r_rx_drop  <= w_rx_drop_nxt;
            r_cmp_cnt  <= r_cmp_cnt + (MAW+1)'(w_cmp_inc) - (MAW+1)'(w_cmp_dec);
            r_state    <= w_state_nxt;
            r_emit_rem <= w_emit_rem_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_nd   <= w_out_nd_nxt;
            r_error    <= r_error | w_m_err | w_m_dropped | w_s_dropped;
        end
    end

    assign out_data = r_out_data;
    assign out_nd   = r_out_nd;
    assign error    = r_error;

`ifdef SAMPLE_MSG_COMBINER_DROP_COUNT_EN
    logic [15:0] r_drop_cnt;
    logic [16:0] w_drop_sum;

    assign w_drop_sum = 17'(r_drop_cnt) + 17'(w_s_dropped) + 17'(w_m_dropped);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_drop_cnt <= '0;
        else        r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end

    assign out_drop_count = r_drop_cnt;
`endif

endmodule
